round_key_server: RTL and testbench

//  Round-key store and streaming responder for the AES datapath. Holds the NUM_ROUNDS+1

---
 rtl/round_key_server.sv | 110 +++++++++++
 tb/tb_round_key_server.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/round_key_server.sv
// rtl/round_key_server.sv - AES round-key store with forward/reverse streaming responder
module round_key_server #(
    parameter int regSize    = 32,
    parameter int vecSize    = 4,
    parameter int NUM_ROUNDS = 10
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             wr_en,
    input  logic [3:0]                       wr_idx,
    input  logic [vecSize-1:0][regSize-1:0]  wr_key,
    input  logic                             start,
    input  logic                             dir,
    input  logic                             key_ready,
    output logic                             key_valid,
    output logic [vecSize-1:0][regSize-1:0]  round_key,
    output logic [3:0]                       round_idx,
    output logic                             last,
    output logic                             busy,
    output logic                             done,
    output logic                             err
);

    localparam logic [3:0] LAST_IDX = 4'(NUM_ROUNDS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SERVE = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t                          state, state_nxt;
    logic [3:0]                      ptr, ptr_nxt;
    logic                            dir_q, dir_nxt;
    logic [NUM_ROUNDS:0]             loaded, loaded_nxt;
    logic                            err_q, err_nxt;
    logic [vecSize-1:0][regSize-1:0] keys [0:NUM_ROUNDS];
    logic                            wr_ok;
    logic [3:0]                      end_idx;

    assign wr_ok   = wr_en && (state == IDLE) && (wr_idx <= LAST_IDX);
    assign end_idx = dir_q ? 4'd0 : LAST_IDX;

    // Start is judged against the mask as it stood before any same-cycle write.
    always_comb begin
        state_nxt  = state;
        ptr_nxt    = ptr;
        dir_nxt    = dir_q;
        loaded_nxt = loaded;
        err_nxt    = 1'b0;
        if (wr_en && ((state != IDLE) || (wr_idx > LAST_IDX)))
            err_nxt = 1'b1;
        if (wr_ok)
            loaded_nxt[wr_idx] = 1'b1;
        case (state)
            IDLE: begin
                if (start) begin
                    if (&loaded) begin
                        state_nxt = SERVE;
                        dir_nxt   = dir;
                        ptr_nxt   = dir ? LAST_IDX : 4'd0;
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
            end
            SERVE: begin
                if (key_ready) begin
                    if (ptr == end_idx)
                        state_nxt = DONE;
                    else
                        ptr_nxt = dir_q ? ptr - 4'd1 : ptr + 4'd1;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            ptr    <= 4'd0;
            dir_q  <= 1'b0;
            loaded <= '0;
            err_q  <= 1'b0;
        end else begin
            state  <= state_nxt;
            ptr    <= ptr_nxt;
            dir_q  <= dir_nxt;
            loaded <= loaded_nxt;
            err_q  <= err_nxt;
        end
    end

    // Contents need no reset: the cleared loaded mask blocks serving until rewritten.
    always_ff @(posedge clk) begin
        if (wr_ok)
            keys[wr_idx] <= wr_key;
    end

    assign key_valid = (state == SERVE);
    assign round_key = key_valid ? keys[ptr] : '0;
    assign round_idx = key_valid ? ptr : 4'd0;
    assign last      = key_valid && (ptr == end_idx);
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);
    assign err       = err_q;

endmodule

// File: tb/tb_round_key_server.sv
// tb/tb_round_key_server.sv - randomized self-checking bench for round_key_server
module tb_round_key_server;

    logic              clk;
    logic              rst;
    logic              wr_en;
    logic [3:0]        wr_idx;
    logic [3:0][31:0]  wr_key;
    logic              start;
    logic              dir;
    logic              key_ready;
    logic              key_valid;
    logic [3:0][31:0]  round_key;
    logic [3:0]        round_idx;
    logic              last;
    logic              busy;
    logic              done;
    logic              err;

    round_key_server dut (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_idx    (wr_idx),
        .wr_key    (wr_key),
        .start     (start),
        .dir       (dir),
        .key_ready (key_ready),
        .key_valid (key_valid),
        .round_key (round_key),
        .round_idx (round_idx),
        .last      (last),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    logic [127:0] fips [11];
    logic [127:0] m_keys [11];
    bit           m_loaded [11];
    int           m_q [$];
    bit           m_done;
    bit           m_err;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic model_clear();
        m_q.delete();
        m_done = 0;
        m_err  = 0;
        for (int i = 0; i < 11; i++) m_loaded[i] = 0;
    endtask

    // Transaction-level reference: pending beats live in a queue filled on an accepted start.
    task automatic step(input logic we, input logic [3:0] wi, input logic [127:0] wk,
                        input logic st, input logic d, input logic kr);
        bit busy_m, all_ld, new_done;
        wr_en = we; wr_idx = wi; wr_key = wk; start = st; dir = d; key_ready = kr;
        busy_m = (m_q.size() != 0) || m_done;
        all_ld = 1;
        for (int i = 0; i < 11; i++) if (!m_loaded[i]) all_ld = 0;
        m_err = (we && (busy_m || wi > 4'd10)) || (!busy_m && st && !all_ld);
        new_done = 0;
        if (m_q.size() != 0) begin
            if (kr) begin
                void'(m_q.pop_front());
                if (m_q.size() == 0) new_done = 1;
            end
        end else if (!busy_m && st && all_ld) begin
            for (int i = 0; i < 11; i++) m_q.push_back(d ? 10 - i : i);
        end
        m_done = new_done;
        if (!busy_m && we && wi <= 4'd10) begin
            m_keys[wi]   = wk;
            m_loaded[wi] = 1;
        end
        @(posedge clk);
        #1;
        check("key_valid", 128'(key_valid), 128'(m_q.size() != 0));
        check("busy", 128'(busy), 128'((m_q.size() != 0) || m_done));
        check("done", 128'(done), 128'(m_done));
        check("err", 128'(err), 128'(m_err));
        if (m_q.size() != 0) begin
            check("round_idx", 128'(round_idx), 128'(m_q[0]));
            check("round_key", 128'(round_key), m_keys[m_q[0]]);
            check("last", 128'(last), 128'(m_q.size() == 1));
        end else begin
            check("round_key_idle", 128'(round_key), 128'd0);
        end
    endtask

    task automatic idle_step(input logic kr);
        step(1'b0, 4'd0, 128'd0, 1'b0, 1'b0, kr);
    endtask

    task automatic load_all(input int skip);
        for (int i = 0; i < 11; i++)
            if (i != skip) step(1'b1, 4'(i), fips[i], 1'b0, 1'b0, 1'b0);
    endtask

    int beats, stalls, bound, exp_idx;
    bit order_ok, seen3;
    logic [3:0]  last_idx;
    logic [31:0] last_col;
    logic        last_flag;

    initial begin
        fips = '{
            128'h09cf4f3c_abf71588_28aed2a6_2b7e1516,
            128'h2a6c7605_23a33939_88542cb1_a0fafe17,
            128'h7359f67f_5935807a_7a96b943_f2c295f2,
            128'h6d7a883b_1e237e44_4716fe3e_3d80477d,
            128'hdb0bad00_b671253b_a8525b7f_ef44a541,
            128'h11f915bc_caf2b8bc_7c839d87_d4d1c6f8,
            128'hca0093fd_dbf98641_110b3efd_6d88a37a,
            128'h4ea6dc4f_84a64fb2_5f5fc9f3_4e54f70e,
            128'h7f8d292f_312bf560_b58dbad2_ead27321,
            128'h575c006e_28d12941_19fadc21_ac7766f3,
            128'hb6630ca6_e13f0cc8_c9ee2589_d014f9a8
        };
        rst = 1'b1; wr_en = 0; wr_idx = 0; wr_key = '0; start = 0; dir = 0; key_ready = 0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", 128'(key_valid), 128'd0);
        check("rst_busy", 128'(busy), 128'd0);
        check("rst_done", 128'(done), 128'd0);
        check("rst_err", 128'(err), 128'd0);
        check("rst_key", 128'(round_key), 128'd0);
        rst = 1'b0;

        // start with nothing loaded
        step(1'b0, 4'd0, 128'd0, 1'b1, 1'b0, 1'b0);
        check("t1_err", 128'(err), 128'd1);
        idle_step(1'b0);

        // all but slot 5 loaded
        load_all(5);
        step(1'b0, 4'd0, 128'd0, 1'b1, 1'b1, 1'b0);
        check("t4_err", 128'(err), 128'd1);
        check("t4_busy", 128'(busy), 128'd0);
        idle_step(1'b0);
        check("t4_err_pulse", 128'(err), 128'd0);
        step(1'b1, 4'd5, fips[5], 1'b0, 1'b0, 1'b0);

        // decrypt order, always ready
        step(1'b0, 4'd0, 128'd0, 1'b1, 1'b1, 1'b1);
        check("t2_first_idx", 128'(round_idx), 128'd10);
        check("t2_first_col0", 128'(round_key[0]), 128'(32'hd014f9a8));
        beats = 0; bound = 0;
        while (key_valid && bound < 20) begin
            beats++; bound++;
            last_idx = round_idx; last_col = round_key[0]; last_flag = last;
            idle_step(1'b1);
        end
        check("t2_beats", 128'(beats), 128'd11);
        check("t2_last_idx", 128'(last_idx), 128'd0);
        check("t2_last_col0", 128'(last_col), 128'(32'h2b7e1516));
        check("t2_last_flag", 128'(last_flag), 128'd1);
        check("t2_done", 128'(done), 128'd1);
        idle_step(1'b0);

        // encrypt order with a 3-cycle stall at beat 4
        step(1'b0, 4'd0, 128'd0, 1'b1, 1'b0, 1'b1);
        beats = 0; stalls = 0; bound = 0; exp_idx = 0; order_ok = 1;
        while (key_valid && bound < 30) begin
            bound++;
            if (round_idx == 4'd4 && stalls < 3) begin
                stalls++;
                idle_step(1'b0);
                check("t3_hold_idx", 128'(round_idx), 128'd4);
            end else begin
                if (int'(round_idx) != exp_idx) order_ok = 0;
                exp_idx++; beats++;
                idle_step(1'b1);
            end
        end
        check("t3_beats", 128'(beats), 128'd11);
        check("t3_order", 128'(order_ok), 128'd1);
        idle_step(1'b0);

        // write during serve is rejected and does not disturb slot 3
        step(1'b0, 4'd0, 128'd0, 1'b1, 1'b0, 1'b1);
        bound = 0; seen3 = 0;
        while (key_valid && bound < 20) begin
            bound++;
            if (round_idx == 4'd1) begin
                step(1'b1, 4'd3, {4{32'hdeadbeef}}, 1'b0, 1'b0, 1'b1);
                check("t5_busy_wr_err", 128'(err), 128'd1);
            end else begin
                if (round_idx == 4'd3) begin
                    check("t5_slot3_kept", 128'(round_key), fips[3]);
                    seen3 = 1;
                end
                idle_step(1'b1);
            end
        end
        check("t5_seen3", 128'(seen3), 128'd1);
        idle_step(1'b0);
        step(1'b1, 4'd11, {4{32'h12345678}}, 1'b0, 1'b0, 1'b0);
        check("t5_idx11_err", 128'(err), 128'd1);

        // asynchronous reset mid-serve clears the mask
        step(1'b0, 4'd0, 128'd0, 1'b1, 1'b0, 1'b1);
        bound = 0;
        while (round_idx != 4'd6 && bound < 20) begin
            bound++;
            idle_step(1'b1);
        end
        check("t6_reached6", 128'(round_idx), 128'd6);
        #2 rst = 1'b1;
        #1;
        check("t6_valid_async", 128'(key_valid), 128'd0);
        check("t6_busy_async", 128'(busy), 128'd0);
        check("t6_key_async", 128'(round_key), 128'd0);
        model_clear();
        @(posedge clk);
        #1 rst = 1'b0;
        step(1'b0, 4'd0, 128'd0, 1'b1, 1'b0, 1'b1);
        check("t6_err_after", 128'(err), 128'd1);

        // randomized traffic against the model
        load_all(-1);
        for (int c = 0; c < 600; c++) begin
            step(($urandom_range(0, 5) == 0), 4'($urandom_range(0, 12)),
                 {$urandom, $urandom, $urandom, $urandom},
                 ($urandom_range(0, 3) == 0), 1'($urandom), ($urandom_range(0, 9) < 7));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
